ssd_frame_decoder: RTL and testbench
====================================

# ssd_frame_decoder

Receive-side counterpart of the seven-segment hex display driver. It accepts a serial stream of active-low seven-segment patterns, one digit per beat, least-significant digit first. It decodes each pattern back to a 4-bit hex nibble and assembles NDIG nibbles into a parallel word, delivered over a valid/ready handshake. It sits between a display-scan capture path and any logic that needs the numeric value being shown.

## Interface
- NDIG, 4: digits per frame; data width is 4*NDIG (default 16).
- Clk  in  1  rising-edge clock.
- Clr_n  in  1  reset. One clock; reset is asynchronous and active-low.
- seg_in  in  7  segment pattern; bit6=g … bit0=a; active-low (0 = lit).
- seg_first  in  1  marks the first (least-significant) digit of a frame.
- seg_valid  in  1  seg_in/seg_first valid this cycle.
- seg_ready  out  1  block accepts a beat this cycle.
- data_out  out  4*NDIG  assembled word; digit k occupies bits [4k+3:4k].
- err_out  out  1  at least one digit in the frame was an undecodable pattern.
- out_valid  out  1  data_out/err_out valid.
- out_ready  in  1  consumer accepts the word.

## Operation
- Beat accepted ⇔ seg_valid && seg_ready.
- Decode is the exact inverse of the display encoding. Active-high g..a patterns:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111
  - 4=1100110, 5=1101101, 6=1111101, 7=0000111
  - 8=1111111, 9=1100111, A=1110111, b=1111100
  - C=0111001, d=1011110, E=1111001, F=1110001
- seg_in is the bitwise complement of these patterns.
- Any other pattern (e.g. blank 7'b1111111) decodes to nibble 0 and sets a sticky frame-error bit.
- FSM states:
  - IDLE: seg_ready=1. An accepted beat with seg_first=1 stores digit 0, sets idx=1, and clears the frame-error bit. If NDIG=1 it goes to HOLD; otherwise it goes to COLLECT. Accepted beats with seg_first=0 are discarded.
  - COLLECT: seg_ready=1. An accepted beat with seg_first=0 stores digit idx and sets idx++. When idx reaches NDIG-1 and that digit is stored, go to HOLD.
  - Restart in COLLECT: an accepted beat with seg_first=1 discards the partial frame, restarts at digit 0 (idx=1), and clears the error bit.
  - HOLD: out_valid=1 and seg_ready=0. data_out and err_out are stable. When out_ready=1, go to IDLE.
- idx width is clog2(NDIG) and never wraps. The terminal digit always forces HOLD.
- data_out keeps its last delivered value outside HOLD. The partial frame is assembled in a separate shadow register.

## Timing
- Reset values: data_out=0, err_out=0, out_valid=0, seg_ready=1, state=IDLE, idx=0, shadow=0.
- Reset is asynchronous: Clr_n low forces the reset values immediately from any state, including mid-frame and HOLD. The partial frame is lost.
- Latency: if the last digit is accepted at edge N, then out_valid=1 and data_out is updated after edge N.
- out_valid is registered. seg_ready is a function of state only, with no combinational path from out_ready.
- If out_ready=1 on the first HOLD cycle, the word is consumed at the next edge and seg_ready=1 the cycle after. Minimum frame-to-frame period is NDIG+1 cycles.
- Gaps in seg_valid within a frame are allowed and do not change the state.

## Structure
- The shared package holds the 16 segment pattern constants (active-high, g..a) and the FSM state enum (IDLE, COLLECT, HOLD). The display driver and this block use the same constants.
- One combinational sub-module, ssd_to_hex: input 7-bit active-low pattern; outputs nibble[3:0] and invalid. It is instantiated once, on seg_in.
- The top module contains the FSM, idx counter, shadow register, error bit, and output registers.

## Test plan
- Frame 0x1234 (beats 4,3,2,1: seg_in=0011001,0110000,0100100,1111001; first=1 on beat 1; out_ready=1) -> data_out=16'h1234, err_out=0, out_valid high exactly one cycle, on the cycle after beat 4.
- All 16 patterns in four frames (0x3210, 0x7654, 0xBA98, 0xFEDC) -> each word is decoded exactly and err_out=0.
- Frame with blank 1111111 as digit 2 (others 0x5) -> data_out=16'h5055, err_out=1. The next clean frame gives err_out=0.
- out_ready=0 for 5 cycles in HOLD -> out_valid and data_out are stable, seg_ready=0, and beats offered meanwhile are ignored. Release -> IDLE, then a new frame is accepted.
- Restart: two digits, then seg_first=1 followed by a full 0xABCD frame -> data_out=16'hABCD. Beats without seg_first in IDLE -> no output.
- Clr_n pulsed low mid-COLLECT, then a full 0x0F0F frame -> outputs return to reset values immediately, then data_out=16'h0F0F.

Source files
------------

// File: rtl/ssd_frame_decoder_pkg.sv
// Shared seven-segment definitions: glyph patterns (active-high, g..a) and
// the frame decoder FSM states. The display driver uses the same table.
package ssd_frame_decoder_pkg;

  // SEG_PAT[k] is the active-high g..a pattern that shows hex digit k.
  localparam logic [15:0][6:0] SEG_PAT = {
    7'b1110001,  // F
    7'b1111001,  // E
    7'b1011110,  // d
    7'b0111001,  // C
    7'b1111100,  // b
    7'b1110111,  // A
    7'b1100111,  // 9
    7'b1111111,  // 8
    7'b0000111,  // 7
    7'b1111101,  // 6
    7'b1101101,  // 5
    7'b1100110,  // 4
    7'b1001111,  // 3
    7'b1011011,  // 2
    7'b0000110,  // 1
    7'b0111111   // 0
  };

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } dec_state_e;

endpackage

// File: rtl/ssd_to_hex.sv
// Combinational inverse of the seven-segment encoder. Unknown glyphs map
// to nibble 0 with invalid raised.
module ssd_to_hex
  import ssd_frame_decoder_pkg::*;
(
  input  logic [6:0] seg_n,
  output logic [3:0] nibble,
  output logic       invalid
);

  logic [6:0] seg;
  assign seg = ~seg_n;

  // Table search; the 16 glyphs are distinct so at most one entry hits.
  always_comb begin
    nibble  = 4'h0;
    invalid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (seg == SEG_PAT[i]) begin
        nibble  = 4'(i);
        invalid = 1'b0;
      end
    end
  end

endmodule

// File: rtl/ssd_frame_decoder.sv
// Serial seven-segment stream to parallel hex word. Digits arrive LSD
// first; a full frame is presented on a valid/ready output and held until
// taken. The partial frame lives in a shadow register so data_out only
// changes when a new word is delivered.
module ssd_frame_decoder
  import ssd_frame_decoder_pkg::*;
#(
  parameter int NDIG = 4
) (
  input  logic              Clk,
  input  logic              Clr_n,
  input  logic [6:0]        seg_in,
  input  logic              seg_first,
  input  logic              seg_valid,
  output logic              seg_ready,
  output logic [4*NDIG-1:0] data_out,
  output logic              err_out,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

  dec_state_e             state, nxt_state;
  logic [IW-1:0]          idx, nxt_idx;
  logic [NDIG-1:0][3:0]   shadow, nxt_shadow;
  logic                   err_q, nxt_err;
  logic                   load;
  logic [3:0]             nib;
  logic                   bad;
  logic                   acc;

  ssd_to_hex u_dec (
    .seg_n   (seg_in),
    .nibble  (nib),
    .invalid (bad)
  );

  // Ready and valid depend on registered state only, never on out_ready.
  assign seg_ready = (state != HOLD);
  assign out_valid = (state == HOLD);
  assign acc       = seg_valid && seg_ready;

  // Next-state: frame start, digit collection, restart, handoff.
  always_comb begin
    nxt_state  = state;
    nxt_idx    = idx;
    nxt_shadow = shadow;
    nxt_err    = err_q;
    load       = 1'b0;
    case (state)
      IDLE, COLLECT: begin
        if (acc && seg_first) begin
          // Frame start (or restart): previous partial frame is dropped.
          nxt_shadow    = '0;
          nxt_shadow[0] = nib;
          nxt_err       = bad;
          nxt_idx       = IW'(1);
          if (NDIG == 1) begin
            nxt_state = HOLD;
            load      = 1'b1;
          end else begin
            nxt_state = COLLECT;
          end
        end else if (acc && state == COLLECT) begin
          nxt_shadow[idx] = nib;
          nxt_err         = err_q | bad;
          if (idx == IW'(NDIG - 1)) begin
            nxt_state = HOLD;
            load      = 1'b1;
          end else begin
            nxt_idx = idx + IW'(1);
          end
        end
      end
      HOLD: begin
        if (out_ready) nxt_state = IDLE;
      end
      default: nxt_state = IDLE;
    endcase
  end

  // State, shadow frame and delivered word; outputs load on the final digit.
  always_ff @(posedge Clk or negedge Clr_n) begin
    if (!Clr_n) begin
      state    <= IDLE;
      idx      <= '0;
      shadow   <= '0;
      err_q    <= 1'b0;
      data_out <= '0;
      err_out  <= 1'b0;
    end else begin
      state  <= nxt_state;
      idx    <= nxt_idx;
      shadow <= nxt_shadow;
      err_q  <= nxt_err;
      if (load) begin
        data_out <= nxt_shadow;
        err_out  <= nxt_err;
      end
    end
  end

endmodule

// File: tb/tb_ssd_frame_decoder.sv
// Randomised + directed bench for ssd_frame_decoder. A frame-level model
// (digit queue, hold flag) predicts handshake and word every cycle.
module tb_ssd_frame_decoder;

  localparam int NDIG = 4;

  logic              Clk = 1'b0;
  logic              Clr_n;
  logic [6:0]        seg_in;
  logic              seg_first;
  logic              seg_valid;
  logic              seg_ready;
  logic [4*NDIG-1:0] data_out;
  logic              err_out;
  logic              out_valid;
  logic              out_ready;

  ssd_frame_decoder #(.NDIG(NDIG)) dut (
    .Clk       (Clk),
    .Clr_n     (Clr_n),
    .seg_in    (seg_in),
    .seg_first (seg_first),
    .seg_valid (seg_valid),
    .seg_ready (seg_ready),
    .data_out  (data_out),
    .err_out   (err_out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 Clk = ~Clk;

  // Glyphs as written in the display table, active-high g..a.
  logic [6:0] glyph [16] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                             7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                             7'b1111111, 7'b1100111, 7'b1110111, 7'b1111100,
                             7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};

  int errs   = 0;
  int checks = 0;

  // Model: frame assembled as a list of digits; a word is pending while hold.
  bit         m_hold;
  bit         m_inframe;
  int         m_cnt;
  logic [15:0] m_acc;
  bit         m_perr;
  logic [15:0] m_word;
  bit         m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [6:0] enc(input int d);
    return ~glyph[d];
  endfunction

  function automatic void decode(input logic [6:0] s, output logic [3:0] n, output bit b);
    n = 4'h0;
    b = 1'b1;
    for (int i = 0; i < 16; i++)
      if (~s == glyph[i]) begin n = 4'(i); b = 1'b0; end
  endfunction

  function automatic void model_reset();
    m_hold = 0; m_inframe = 0; m_cnt = 0; m_acc = '0; m_perr = 0;
    m_word = '0; m_err = 0;
  endfunction

  // One clock: drive at negedge, check outputs, advance model across posedge.
  task automatic cycle(input bit v, input bit f, input logic [6:0] s, input bit ordy);
    logic [3:0] n;
    bit b;
    seg_valid = v; seg_first = f; seg_in = s; out_ready = ordy;
    #1;
    chk("seg_ready", seg_ready, !m_hold);
    chk("out_valid", out_valid, m_hold);
    chk("data_out", data_out, m_word);
    chk("err_out", err_out, m_err);
    if (m_hold) begin
      if (ordy) m_hold = 0;
    end else if (v) begin
      decode(s, n, b);
      if (f) begin
        m_acc = '0; m_acc[3:0] = n; m_perr = b; m_cnt = 1; m_inframe = 1;
      end else if (m_inframe) begin
        m_acc[4*m_cnt +: 4] = n; m_perr = m_perr | b; m_cnt++;
      end
      if (m_inframe && m_cnt == NDIG) begin
        m_word = m_acc; m_err = m_perr; m_hold = 1; m_inframe = 0;
      end
    end
    @(negedge Clk);
  endtask

  // Full frame LSD first; bad_pos marks a digit sent as blank, gap adds an idle beat.
  task automatic frame(input logic [15:0] w, input int bad_pos, input bit gap, input bit ordy);
    for (int i = 0; i < NDIG; i++) begin
      cycle(1, i == 0, (i == bad_pos) ? 7'h7f : enc(int'(w[4*i +: 4])), ordy);
      if (gap && i == 1) cycle(0, 0, 7'h00, ordy);
    end
  endtask

  initial begin
    Clr_n = 0; seg_valid = 0; seg_first = 0; seg_in = 7'h7f; out_ready = 0;
    model_reset();
    #12;
    chk("rst_ready", seg_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", data_out, 0);
    chk("rst_err", err_out, 0);
    @(negedge Clk);
    Clr_n = 1;
    @(negedge Clk);

    // 0x1234 and one-cycle valid
    frame(16'h1234, -1, 0, 1);
    chk("f1234_data", data_out, 16'h1234);
    cycle(0, 0, 7'h00, 1);
    cycle(0, 0, 7'h00, 1);

    // all sixteen glyphs
    frame(16'h3210, -1, 0, 1); cycle(0, 0, 7'h00, 1);
    frame(16'h7654, -1, 1, 1); cycle(0, 0, 7'h00, 1);
    frame(16'hBA98, -1, 0, 1); cycle(0, 0, 7'h00, 1);
    frame(16'hFEDC, -1, 1, 1); cycle(0, 0, 7'h00, 1);
    chk("fFEDC_data", data_out, 16'hFEDC);

    // blank in digit 2, then a clean frame clears err
    frame(16'h5555, 2, 0, 1);
    chk("blank_data", data_out, 16'h5055);
    chk("blank_err", err_out, 1);
    cycle(0, 0, 7'h00, 1);
    frame(16'h5555, -1, 0, 1);
    chk("clean_err", err_out, 0);
    cycle(0, 0, 7'h00, 1);

    // hold with back-pressure while beats are offered
    frame(16'h2468, -1, 0, 0);
    for (int i = 0; i < 5; i++) cycle(1, i == 0, enc(i + 3), 0);
    cycle(0, 0, 7'h00, 1);
    frame(16'h9ACE, -1, 0, 1); cycle(0, 0, 7'h00, 1);

    // restart mid-frame, then stray non-first beats in IDLE
    cycle(1, 1, enc(1), 1);
    cycle(1, 0, enc(2), 1);
    frame(16'hABCD, -1, 0, 1);
    chk("restart_data", data_out, 16'hABCD);
    cycle(0, 0, 7'h00, 1);
    for (int i = 0; i < 4; i++) cycle(1, 0, enc(7), 1);
    cycle(0, 0, 7'h00, 1);

    // async reset mid-COLLECT
    cycle(1, 1, enc(9), 1);
    cycle(1, 0, enc(8), 1);
    seg_valid = 0;
    Clr_n = 0;
    #1;
    model_reset();
    chk("arst_ready", seg_ready, 1);
    chk("arst_valid", out_valid, 0);
    chk("arst_data", data_out, 0);
    chk("arst_err", err_out, 0);
    @(negedge Clk);
    Clr_n = 1;
    cycle(0, 0, 7'h00, 1);
    frame(16'h0F0F, -1, 0, 1);
    chk("f0F0F_data", data_out, 16'h0F0F);
    cycle(0, 0, 7'h00, 1);

    // random traffic
    for (int k = 0; k < 600; k++) begin
      bit v, f, r;
      logic [6:0] s;
      v = ($urandom_range(0, 9) < 7);
      f = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 9) < 6);
      s = ($urandom_range(0, 9) == 0) ? 7'($urandom) : enc($urandom_range(0, 15));
      cycle(v, f, s, r);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
